huffman_table_loader: RTL and testbench
=======================================

# huffman_table_loader

Fills the `roms` code-table bank of the Huffman encoder over its write port, then reads every entry back to prove the load. It accepts a 64-bit word stream with a valid/ready handshake and broadcasts each word to all ROM blocks at the same address. After all 256 words are written, it reads each ROM back and checks an XOR checksum. It then raises `tbl_ready` so the encoder can take ownership of the ROM port.

## Interface
- `ROM_NUM`, 1, number of ROM blocks driven; matches the `roms` instance.
- `ADDR_WIDTH`, 8, address width per ROM; depth is 2^ADDR_WIDTH = 256.
- `DATA_WIDTH`, 64, table word width.
- `RD_LAT`, 1, ROM read latency in cycles from `rom_addr` valid to `rom_dout` valid; legal range 1..2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a load when in IDLE; ignored otherwise.
- `s_valid` in 1: input table word valid.
- `s_ready` out 1: loader accepts a word.
- `s_data` in DATA_WIDTH: table word; words arrive in address order 0..255.
- `rom_addr` out ROM_NUM*ADDR_WIDTH: per-ROM address; all slices are always equal.
- `rom_we` out 1: shared write enable.
- `rom_din` out DATA_WIDTH*ROM_NUM: the input word replicated into every slice.
- `rom_dout` in DATA_WIDTH*ROM_NUM: readback data from the ROMs.
- `busy` out 1: high in LOAD, VERIFY and CHECK.
- `done` out 1: one-cycle pulse when the sequence ends.
- `err` out 1: sticky checksum mismatch; cleared by `start`.
- `tbl_ready` out 1: tables are valid and the encoder may own the ROM port; cleared by `start`.

## Operation
- States:
  - IDLE -> LOAD on `start`.
  - LOAD -> VERIFY after the beat at address 255.
  - VERIFY -> CHECK after address 255 is issued and RD_LAT drain cycles complete.
  - CHECK -> IDLE in one cycle.
- IDLE:
  - `s_ready`=0, `rom_we`=0, `rom_addr`=0, `rom_din`=0.
  - `start` clears `err`, `tbl_ready`, the address counter and all accumulators.
- LOAD:
  - `s_ready`=1.
  - Each handshake (`s_valid`&&`s_ready`) XORs `s_data` into `ld_sum` and writes the word at the current counter value.
  - The counter increments once per beat. Stalls (`s_valid`=0) hold the counter and deassert `rom_we`.
- VERIFY:
  - `s_ready`=0, `rom_we`=0.
  - Issues addresses 0..255 on consecutive cycles.
  - Each ROM slice i XORs its `rom_dout` slice into `rd_sum[i]` exactly RD_LAT cycles after the address is driven; a delay line of valid bits tracks this.
- CHECK:
  - `err` = OR over i of (`rd_sum[i]` != `ld_sum`).
  - `tbl_ready` = !`err`.
  - `done` pulses.
- Counter width is ADDR_WIDTH. It wraps from 255 to 0 at the LOAD->VERIFY boundary and is never otherwise compared past 255.
- `start` while `busy` is ignored and does not restart the sequence.

## Timing
- Reset value of every output is 0, including `tbl_ready` and `err`. Accumulators and state reset to 0/IDLE.
- `rom_addr`, `rom_we` and `rom_din` are registered. A beat accepted at cycle t produces the write on the ROM port in cycle t+1.
- `s_ready` is a registered state decode, not combinational from `s_valid`.
- Minimum sequence, with `start` at cycle 0 and `s_valid` held high:
  - LOAD occupies cycles 1..256.
  - VERIFY issues addresses over 256 cycles plus RD_LAT drain.
  - CHECK, with `done` high, follows: total ≈ 514+RD_LAT cycles.
- Reset asserted mid-LOAD or mid-VERIFY aborts immediately:
  - `rom_we` drops asynchronously.
  - `tbl_ready` stays 0 until a full successful sequence completes.
- `done` and the `tbl_ready` rise occur in the same cycle. `err` and `tbl_ready` are never both 1.

## Structure
- Package `huffman_rom_pkg` holds:
  - the ADDR_WIDTH=8, DATA_WIDTH=64 and DEPTH=256 constants shared with `roms`;
  - the loader state encoding (IDLE, LOAD, VERIFY, CHECK).
- Sub-module `huffman_tbl_xor_acc`: one per ROM slice via generate. It is a clear/enable/data XOR accumulator with RD_LAT valid alignment.
- The top level holds the FSM, address counter, handshake and the `ld_sum` accumulator.

## Test plan
- Basic load:
  - Stimulus: ROM_NUM=2; `start`, then words data[k]=64'h0123_4567_0000_0000+k for k=0..255, with `s_valid` always high and a behavioural BRAM model.
  - Required: `done` at cycle 514+RD_LAT; `tbl_ready`=1; `err`=0; both ROM models hold data[k] at address k.
- Back-pressure:
  - Stimulus: `s_valid` toggling 1/0 every cycle.
  - Required: exactly 256 `rom_we` pulses at addresses 0..255 in order; no address is skipped or repeated; result is identical to the basic load.
- Corrupt readback:
  - Stimulus: the model flips bit 5 of ROM1 address 0x80 on read.
  - Required: `err`=1, `tbl_ready`=0, `done` pulses once.
- Ignored start:
  - Stimulus: `start` pulsed at beat 100 of LOAD.
  - Required: no restart; sequence completes normally; `tbl_ready`=1.
- Reset mid-verify:
  - Stimulus: `rst_n` low at VERIFY address 0x40.
  - Required: all outputs 0 immediately; a subsequent full load gives `tbl_ready`=1.
- Read latency:
  - Stimulus: RD_LAT=2 with the basic load stimulus.
  - Required: checksum passes; `done` occurs one cycle later than in the RD_LAT=1 case.

Source files
------------

// File: rtl/huffman_rom_pkg.sv
// Shared constants for the Huffman code-table ROM bank and the loader state encoding.
package huffman_rom_pkg;

   localparam int ROM_ADDR_WIDTH = 8;
   localparam int ROM_DATA_WIDTH = 64;
   localparam int ROM_DEPTH      = 256;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_CHECK  = 2'd3
   } ld_state_e;

endpackage

// File: rtl/huffman_tbl_xor_acc.sv
// Per-ROM-slice XOR accumulator; a valid delay line aligns accumulation with the ROM read latency.
module huffman_tbl_xor_acc
   import huffman_rom_pkg::*;
#(
   parameter int DATA_WIDTH = ROM_DATA_WIDTH,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  vld_in,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] rd_sum_nxt
);

   logic [RD_LAT-1:0]     vld_q, vld_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;

   always_comb begin
      vld_d    = '0;
      vld_d[0] = vld_in;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
      end
      sum_d = sum_q;
      if (clr) begin
         vld_d = '0;
         sum_d = '0;
      end else if (vld_q[RD_LAT-1]) begin
         sum_d = sum_q ^ din;
      end
   end

   // The next value is exported so the final check can see the last word in the cycle it lands.
   assign rd_sum_nxt = sum_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         sum_q <= '0;
      end else begin
         vld_q <= vld_d;
         sum_q <= sum_d;
      end
   end

endmodule

// File: rtl/huffman_table_loader.sv
// Loads the Huffman code-table ROM bank from a valid/ready word stream, reads it back and
// checks an XOR checksum before handing the ROM port to the encoder via tbl_ready.
module huffman_table_loader
   import huffman_rom_pkg::*;
#(
   parameter int ROM_NUM    = 1,
   parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
   parameter int DATA_WIDTH = ROM_DATA_WIDTH,
   parameter int RD_LAT     = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_WIDTH-1:0]         s_data,
   output logic [ROM_NUM*ADDR_WIDTH-1:0] rom_addr,
   output logic                          rom_we,
   output logic [DATA_WIDTH*ROM_NUM-1:0] rom_din,
   input  logic [DATA_WIDTH*ROM_NUM-1:0] rom_dout,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic                          tbl_ready
);

   localparam logic [1:0] DRN_LAST = 2'(RD_LAT);

   ld_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_WIDTH-1:0] rom_din_q, rom_din_d;
   logic [DATA_WIDTH-1:0] ld_sum_q, ld_sum_d;
   logic                  rom_we_q, rom_we_d;
   logic                  s_ready_q, s_ready_d;
   logic                  iss_vld_q, iss_vld_d;
   logic                  issued_q, issued_d;
   logic [1:0]            drn_q, drn_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  tbl_ready_q, tbl_ready_d;
   logic                  acc_clr;
   logic                  rd_mismatch;
   logic [DATA_WIDTH-1:0] rd_sum_nxt [ROM_NUM];

   for (genvar g = 0; g < ROM_NUM; g++) begin : g_acc
      huffman_tbl_xor_acc #(
         .DATA_WIDTH (DATA_WIDTH),
         .RD_LAT     (RD_LAT)
      ) u_acc (
         .clk        (clk),
         .rst_n      (rst_n),
         .clr        (acc_clr),
         .vld_in     (iss_vld_q),
         .din        (rom_dout[g*DATA_WIDTH +: DATA_WIDTH]),
         .rd_sum_nxt (rd_sum_nxt[g])
      );
   end

   always_comb begin
      rd_mismatch = 1'b0;
      for (int i = 0; i < ROM_NUM; i++) begin
         if (rd_sum_nxt[i] != ld_sum_q) rd_mismatch = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rom_addr_d  = rom_addr_q;
      rom_din_d   = '0;
      ld_sum_d    = ld_sum_q;
      rom_we_d    = 1'b0;
      s_ready_d   = 1'b0;
      iss_vld_d   = 1'b0;
      issued_d    = issued_q;
      drn_d       = drn_q;
      done_d      = 1'b0;
      err_d       = err_q;
      tbl_ready_d = tbl_ready_q;
      acc_clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rom_addr_d = '0;
            if (start) begin
               state_d     = ST_LOAD;
               cnt_d       = '0;
               ld_sum_d    = '0;
               issued_d    = 1'b0;
               drn_d       = '0;
               err_d       = 1'b0;
               tbl_ready_d = 1'b0;
               acc_clr     = 1'b1;
               s_ready_d   = 1'b1;
            end
         end
         ST_LOAD: begin
            s_ready_d = 1'b1;
            if (s_valid && s_ready_q) begin
               rom_we_d   = 1'b1;
               rom_addr_d = cnt_q;
               rom_din_d  = s_data;
               ld_sum_d   = ld_sum_q ^ s_data;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_d   = ST_VERIFY;
                  s_ready_d = 1'b0;
               end
            end
         end
         ST_VERIFY: begin
            if (!issued_q) begin
               rom_addr_d = cnt_q;
               iss_vld_d  = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == '1) issued_d = 1'b1;
            end else if (drn_q == DRN_LAST) begin
               // The last readback word is accumulating on this edge, so judge its next sum.
               state_d     = ST_CHECK;
               done_d      = 1'b1;
               err_d       = rd_mismatch;
               tbl_ready_d = !rd_mismatch;
            end else begin
               drn_d = drn_q + 2'd1;
            end
         end
         ST_CHECK: begin
            state_d    = ST_IDLE;
            rom_addr_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rom_addr_q  <= '0;
         rom_din_q   <= '0;
         ld_sum_q    <= '0;
         rom_we_q    <= 1'b0;
         s_ready_q   <= 1'b0;
         iss_vld_q   <= 1'b0;
         issued_q    <= 1'b0;
         drn_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         tbl_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rom_addr_q  <= rom_addr_d;
         rom_din_q   <= rom_din_d;
         ld_sum_q    <= ld_sum_d;
         rom_we_q    <= rom_we_d;
         s_ready_q   <= s_ready_d;
         iss_vld_q   <= iss_vld_d;
         issued_q    <= issued_d;
         drn_q       <= drn_d;
         done_q      <= done_d;
         err_q       <= err_d;
         tbl_ready_q <= tbl_ready_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign rom_addr  = {ROM_NUM{rom_addr_q}};
   assign rom_we    = rom_we_q;
   assign rom_din   = {ROM_NUM{rom_din_q}};
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign tbl_ready = tbl_ready_q;

endmodule

// File: tb/tb_huffman_table_loader.sv
// Directed bench: two loaders (RD_LAT=1 and RD_LAT=2, two ROMs each) share one stimulus stream.
module tb_huffman_table_loader;

   localparam int RN = 2;
   localparam int AW = 8;
   localparam int DW = 64;
   localparam logic [DW-1:0] BASE = 64'h0123_4567_0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, s_valid;
   logic [DW-1:0] s_data;

   logic              s_ready1, rom_we1, busy1, done1, err1, tbr1;
   logic [RN*AW-1:0]  rom_addr1;
   logic [DW*RN-1:0]  rom_din1, rom_dout1;
   logic              s_ready2, rom_we2, busy2, done2, err2, tbr2;
   logic [RN*AW-1:0]  rom_addr2;
   logic [DW*RN-1:0]  rom_din2, rom_dout2, pre2;

   huffman_table_loader #(.ROM_NUM(RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready1),
      .s_data(s_data), .rom_addr(rom_addr1), .rom_we(rom_we1), .rom_din(rom_din1),
      .rom_dout(rom_dout1), .busy(busy1), .done(done1), .err(err1), .tbl_ready(tbr1));

   huffman_table_loader #(.ROM_NUM(RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready2),
      .s_data(s_data), .rom_addr(rom_addr2), .rom_we(rom_we2), .rom_din(rom_din2),
      .rom_dout(rom_dout2), .busy(busy2), .done(done2), .err(err2), .tbl_ready(tbr2));

   // Behavioural BRAMs: dut1 ROMs read in one cycle, dut2 ROMs in two.
   logic [DW-1:0] m1a [256];
   logic [DW-1:0] m1b [256];
   logic [DW-1:0] m2a [256];
   logic [DW-1:0] m2b [256];
   logic          corrupt, clr_mem;

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 256; i++) begin
            m1a[i] <= '0; m1b[i] <= '0; m2a[i] <= '0; m2b[i] <= '0;
         end
      end else begin
         if (rom_we1) begin
            m1a[rom_addr1[7:0]]  <= rom_din1[63:0];
            m1b[rom_addr1[15:8]] <= rom_din1[127:64];
         end
         if (rom_we2) begin
            m2a[rom_addr2[7:0]]  <= rom_din2[63:0];
            m2b[rom_addr2[15:8]] <= rom_din2[127:64];
         end
      end
      rom_dout1 <= {m1b[rom_addr1[15:8]] ^ ((corrupt && rom_addr1[15:8] == 8'h80) ? 64'h20 : 64'h0),
                    m1a[rom_addr1[7:0]]};
      pre2      <= {m2b[rom_addr2[15:8]], m2a[rom_addr2[7:0]]};
      rom_dout2 <= pre2;
   end

   int nchk = 0;
   int nfail = 0;
   int d1_at, d2_at, we_cnt, ord_err, dp1, dp2, excl_err;
   bit aborted;

   task automatic clear_mems();
      clr_mem = 1'b1;
      @(posedge clk); #1;
      clr_mem = 1'b0;
   endtask

   function automatic int mem_bad(input bit which);
      int bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (!which) begin
            if (m1a[i] !== BASE + 64'(i)) bad++;
            if (m1b[i] !== BASE + 64'(i)) bad++;
         end else begin
            if (m2a[i] !== BASE + 64'(i)) bad++;
            if (m2b[i] !== BASE + 64'(i)) bad++;
         end
      end
      return bad;
   endfunction

   // Runs one load; cycle 0 is the cycle in which start is high.
   task automatic run_load(input bit bp, input bit mid_start, input bit mid_rst);
      int  idx = 0;
      int  tail = 0;
      bit  acc;
      bit  ms_done = 1'b0;
      d1_at = -1; d2_at = -1; we_cnt = 0; ord_err = 0; dp1 = 0; dp2 = 0; excl_err = 0;
      aborted = 1'b0;
      s_data = BASE; s_valid = 1'b1; start = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         acc = s_valid && s_ready1;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) idx++;
         if (rom_we1) begin
            if (rom_addr1 !== {2{we_cnt[7:0]}}) ord_err++;
            we_cnt++;
         end
         if (done1) begin dp1++; if (d1_at < 0) d1_at = k + 1; end
         if (done2) begin dp2++; if (d2_at < 0) d2_at = k + 1; end
         if ((err1 && tbr1) || (err2 && tbr2)) excl_err++;
         s_valid = bp ? ((k % 2) == 1) : 1'b1;
         s_data  = BASE + 64'(idx);
         if (mid_start && !ms_done && idx == 100 && s_ready1) begin
            start = 1'b1;
            ms_done = 1'b1;
         end
         if (mid_rst && busy1 && !s_ready1 && !rom_we1 && rom_addr1[7:0] == 8'h40) begin
            rst_n = 1'b0;
            #1;
            nchk++;
            if ({s_ready1, rom_we1, busy1, done1, err1, tbr1, rom_addr1, rom_din1} !== '0) begin
               nfail++;
               $display("FAIL rst_mid_dut1: outputs=%h required 0",
                        {s_ready1, rom_we1, busy1, done1, err1, tbr1, rom_addr1, rom_din1});
            end
            nchk++;
            if ({s_ready2, rom_we2, busy2, done2, err2, tbr2, rom_addr2, rom_din2} !== '0) begin
               nfail++;
               $display("FAIL rst_mid_dut2: outputs=%h required 0",
                        {s_ready2, rom_we2, busy2, done2, err2, tbr2, rom_addr2, rom_din2});
            end
            aborted = 1'b1;
            break;
         end
         if (d1_at >= 0 && d2_at >= 0) begin
            tail++;
            if (tail > 3) break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; corrupt = 1'b0; clr_mem = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      nchk++;
      if ({s_ready1, rom_we1, busy1, done1, err1, tbr1} !== 6'b0) begin
         nfail++;
         $display("FAIL reset_ctrl1: got %b required 000000", {s_ready1, rom_we1, busy1, done1, err1, tbr1});
      end
      nchk++;
      if (rom_addr1 !== '0 || rom_din1 !== '0) begin
         nfail++;
         $display("FAIL reset_port1: addr=%h din=%h required 0", rom_addr1, rom_din1);
      end
      nchk++;
      if ({s_ready2, rom_we2, busy2, done2, err2, tbr2} !== 6'b0) begin
         nfail++;
         $display("FAIL reset_ctrl2: got %b required 000000", {s_ready2, rom_we2, busy2, done2, err2, tbr2});
      end
      clr_mem = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      nchk++;
      if (s_ready1 !== 1'b0 || busy1 !== 1'b0) begin
         nfail++;
         $display("FAIL idle_no_start: s_ready=%b busy=%b required 0 0", s_ready1, busy1);
      end
   endtask

   task automatic check_good(input string tag, input int exp_d1);
      nchk++;
      if (d1_at != exp_d1) begin
         nfail++; $display("FAIL %s_done1_cycle: got %0d required %0d", tag, d1_at, exp_d1);
      end
      nchk++;
      if (d2_at != exp_d1 + 1) begin
         nfail++; $display("FAIL %s_done2_cycle: got %0d required %0d", tag, d2_at, exp_d1 + 1);
      end
      nchk++;
      if ({tbr1, err1, tbr2, err2} !== 4'b1010) begin
         nfail++; $display("FAIL %s_status: tbr1/err1/tbr2/err2=%b required 1010", tag, {tbr1, err1, tbr2, err2});
      end
      nchk++;
      if (mem_bad(1'b0) != 0) begin
         nfail++; $display("FAIL %s_mem1: %0d bad entries required 0", tag, mem_bad(1'b0));
      end
      nchk++;
      if (mem_bad(1'b1) != 0) begin
         nfail++; $display("FAIL %s_mem2: %0d bad entries required 0", tag, mem_bad(1'b1));
      end
      nchk++;
      if (dp1 != 1 || dp2 != 1) begin
         nfail++; $display("FAIL %s_done_pulses: got %0d/%0d required 1/1", tag, dp1, dp2);
      end
      nchk++;
      if (excl_err != 0) begin
         nfail++; $display("FAIL %s_err_and_ready: %0d cycles with both high required 0", tag, excl_err);
      end
   endtask

   task automatic test_basic_load();
      clear_mems();
      run_load(1'b0, 1'b0, 1'b0);
      check_good("basic", 515);
      nchk++;
      if (we_cnt != 256 || ord_err != 0) begin
         nfail++; $display("FAIL basic_writes: count=%0d order_errors=%0d required 256/0", we_cnt, ord_err);
      end
   endtask

   task automatic test_back_pressure();
      clear_mems();
      run_load(1'b1, 1'b0, 1'b0);
      check_good("bp", 771);
      nchk++;
      if (we_cnt != 256 || ord_err != 0) begin
         nfail++; $display("FAIL bp_writes: count=%0d order_errors=%0d required 256/0", we_cnt, ord_err);
      end
   endtask

   task automatic test_corrupt_readback();
      corrupt = 1'b1;
      run_load(1'b0, 1'b0, 1'b0);
      corrupt = 1'b0;
      nchk++;
      if ({err1, tbr1} !== 2'b10) begin
         nfail++; $display("FAIL corrupt_status1: err/tbl_ready=%b required 10", {err1, tbr1});
      end
      nchk++;
      if (dp1 != 1) begin
         nfail++; $display("FAIL corrupt_done_pulses: got %0d required 1", dp1);
      end
      nchk++;
      if ({err2, tbr2} !== 2'b01) begin
         nfail++; $display("FAIL corrupt_status2: err/tbl_ready=%b required 01", {err2, tbr2});
      end
      nchk++;
      if (excl_err != 0) begin
         nfail++; $display("FAIL corrupt_err_and_ready: %0d cycles required 0", excl_err);
      end
   endtask

   task automatic test_ignored_start();
      clear_mems();
      run_load(1'b0, 1'b1, 1'b0);
      check_good("istart", 515);
      nchk++;
      if (we_cnt != 256 || ord_err != 0) begin
         nfail++; $display("FAIL istart_writes: count=%0d order_errors=%0d required 256/0", we_cnt, ord_err);
      end
   endtask

   task automatic test_reset_mid_verify();
      run_load(1'b0, 1'b0, 1'b1);
      nchk++;
      if (!aborted) begin
         nfail++; $display("FAIL rst_mid_reached: aborted=%b required 1", aborted);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      nchk++;
      if ({tbr1, tbr2, busy1} !== 3'b000) begin
         nfail++; $display("FAIL rst_mid_after: tbr1/tbr2/busy=%b required 000", {tbr1, tbr2, busy1});
      end
      clear_mems();
      run_load(1'b0, 1'b0, 1'b0);
      check_good("reload", 515);
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_back_pressure();
      test_corrupt_readback();
      test_ignored_start();
      test_reset_mid_verify();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end

endmodule
